// File: rtl/mem_pkg.sv
// Shared memory-subsystem constants and the load/store sequencer state type.
// memWrapper uses the geometry constants as well.
package mem_pkg;
    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 16;
    localparam int MEM_WORDS   = 1024;
    localparam int FAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mau_state_e;
endpackage

// File: rtl/mem_fault_tracker.sv
// Sticky fault flag plus saturating fault counter.
// A clear arriving together with a fault wins, so that fault is dropped.
module mem_fault_tracker
    import mem_pkg::*;
#(
    parameter int CNT_W = FAULT_CNT_W
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             fault_evt_i,
    input  logic             fault_clr_i,
    output logic             fault_sticky_o,
    output logic [CNT_W-1:0] fault_count_o
);
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] count_q,  count_d;

    always_comb begin
        sticky_d = sticky_q;
        count_d  = count_q;
        if (fault_clr_i) begin
            sticky_d = 1'b0;
            count_d  = '0;
        end else if (fault_evt_i) begin
            sticky_d = 1'b1;
            if (count_q != {CNT_W{1'b1}})
                count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign fault_sticky_o = sticky_q;
    assign fault_count_o  = count_q;
endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store sequencer in front of memWrapper: latches a
// request, issues it, waits out the read latency and pulses one response.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W       = mem_pkg::DATA_W,
    parameter int ADDR_W       = mem_pkg::ADDR_W,
    parameter int MEM_WORDS    = mem_pkg::MEM_WORDS,
    parameter int READ_LATENCY = 1
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   resp_valid,
    output logic [DATA_W-1:0]      resp_rdata,
    output logic                   resp_fault,
    output logic                   fault_sticky,
    input  logic                   fault_clr,
    output logic [FAULT_CNT_W-1:0] fault_count,
    output logic [ADDR_W-1:0]      MemAddr,
    output logic [DATA_W-1:0]      MemDIn,
    output logic                   MemWriteEnable,
    input  logic [DATA_W-1:0]      MemDOut,
    input  logic                   MemOOB
);
    mau_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              write_q, write_d;
    logic              oob_q,   oob_d;
    logic [1:0]        cnt_q,   cnt_d;
    logic              oob;

    // MemOOB only means something while the latched address is on MemAddr.
    assign oob = (32'(addr_q) >= 32'(MEM_WORDS)) || MemOOB;

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        write_d        = write_q;
        rdata_d        = rdata_q;
        oob_d          = oob_q;
        cnt_d          = cnt_q;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_fault     = 1'b0;
        MemWriteEnable = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;
                    rdata_d = '0;
                    oob_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                MemWriteEnable = write_q && !oob;
                oob_d          = oob;
                if (write_q) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = 2'(READ_LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    rdata_d = oob_q ? '0 : MemDOut;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_fault = oob_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            oob_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            oob_q   <= oob_d;
            cnt_q   <= cnt_d;
        end
    end

    assign MemAddr    = addr_q;
    assign MemDIn     = wdata_q;
    assign resp_rdata = rdata_q;

    mem_fault_tracker #(.CNT_W(FAULT_CNT_W)) u_fault (
        .CLK           (CLK),
        .Reset         (Reset),
        .fault_evt_i   (resp_valid && resp_fault),
        .fault_clr_i   (fault_clr),
        .fault_sticky_o(fault_sticky),
        .fault_count_o (fault_count)
    );
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: default-latency unit on a modelled memory, plus a
// READ_LATENCY=3 unit for latency and handshake-hold checks.
module tb_mem_access_unit;
    logic        clk, Reset;
    // instance 0: READ_LATENCY = 1
    logic        req_valid, req_ready, req_write, resp_valid, resp_fault;
    logic [15:0] req_addr, req_wdata, resp_rdata;
    logic        fault_sticky, fault_clr, MemWriteEnable, MemOOB;
    logic [7:0]  fault_count;
    logic [15:0] MemAddr, MemDIn, MemDOut;
    // instance 1: READ_LATENCY = 3
    logic        r_valid, r_ready, r_write, r_resp_valid, r_resp_fault;
    logic [15:0] r_addr, r_wdata, r_rdata;
    logic        r_sticky, r_clr, r_we, r_oob;
    logic [7:0]  r_count;
    logic [15:0] r_maddr, r_mdin, r_mdout, r_p1, r_p2;

    logic [15:0] mem0 [1024];
    int errors = 0, checks = 0;

    mem_access_unit dut0 (
        .CLK(clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .fault_sticky(fault_sticky), .fault_clr(fault_clr), .fault_count(fault_count),
        .MemAddr(MemAddr), .MemDIn(MemDIn), .MemWriteEnable(MemWriteEnable),
        .MemDOut(MemDOut), .MemOOB(MemOOB));

    mem_access_unit #(.READ_LATENCY(3)) dut1 (
        .CLK(clk), .Reset(Reset), .req_valid(r_valid), .req_ready(r_ready),
        .req_write(r_write), .req_addr(r_addr), .req_wdata(r_wdata),
        .resp_valid(r_resp_valid), .resp_rdata(r_rdata), .resp_fault(r_resp_fault),
        .fault_sticky(r_sticky), .fault_clr(r_clr), .fault_count(r_count),
        .MemAddr(r_maddr), .MemDIn(r_mdin), .MemWriteEnable(r_we),
        .MemDOut(r_mdout), .MemOOB(r_oob));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous memory, one-edge read latency, preloaded word[i] = i in reset.
    assign MemOOB = (MemAddr >= 16'd1024);
    always @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < 1024; i++) mem0[i] <= 16'(i);
        end else if (MemWriteEnable) begin
            mem0[MemAddr[9:0]] <= MemDIn;
        end
        MemDOut <= MemOOB ? 16'h0 : mem0[MemAddr[9:0]];
    end

    // Read-only identity memory with three-edge latency for instance 1.
    assign r_oob = (r_maddr >= 16'd1024);
    always @(posedge clk) begin
        r_p1    <= r_oob ? 16'h0 : r_maddr;
        r_p2    <= r_p1;
        r_mdout <= r_p2;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request on instance 0 and report the response and its latency
    // in cycles after the accepting edge.
    task automatic run_req(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                           output logic [15:0] rd, output logic flt, output int lat, output int wes);
        rd = 16'h0; flt = 1'b0; lat = -1; wes = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (MemWriteEnable) wes++;
            if (resp_valid) begin
                rd = resp_rdata; flt = resp_fault; lat = k;
                break;
            end
        end
        if (lat < 0) check("resp_timeout", 32'(0), 32'(1));
    endtask

    logic [15:0] rd;
    logic        flt;
    int          lat, wes, seen;

    initial begin
        Reset = 1'b1; fault_clr = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        r_valid = 1'b0; r_write = 1'b0; r_addr = '0; r_wdata = '0; r_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'(1));
        check("rst_resp_valid", 32'(resp_valid), 32'(0));
        check("rst_count", 32'(fault_count), 32'(0));
        check("rst_memaddr", 32'(MemAddr), 32'(0));
        Reset = 1'b0;

        run_req(1'b0, 16'd23, 16'h0, rd, flt, lat, wes);
        check("ld23_lat", 32'(lat), 32'(3));
        check("ld23_data", 32'(rd), 32'(23));
        check("ld23_fault", 32'(flt), 32'(0));
        check("ld23_we", 32'(wes), 32'(0));

        run_req(1'b1, 16'd332, 16'd166, rd, flt, lat, wes);
        check("st332_lat", 32'(lat), 32'(2));
        check("st332_we", 32'(wes), 32'(1));
        check("st332_rdata", 32'(rd), 32'(0));
        run_req(1'b0, 16'd332, 16'h0, rd, flt, lat, wes);
        check("ld332_data", 32'(rd), 32'(166));

        run_req(1'b1, 16'd1023, 16'hFFFF, rd, flt, lat, wes);
        check("st1023_fault", 32'(flt), 32'(0));
        run_req(1'b0, 16'd1023, 16'h0, rd, flt, lat, wes);
        check("ld1023_data", 32'(rd), 32'hFFFF);

        run_req(1'b1, 16'd1024, 16'h1234, rd, flt, lat, wes);
        check("st1024_fault", 32'(flt), 32'(1));
        check("st1024_we", 32'(wes), 32'(0));
        @(negedge clk);
        check("st1024_sticky", 32'(fault_sticky), 32'(1));
        check("st1024_count", 32'(fault_count), 32'(1));
        // a misrouted store to 1024 would alias onto word 0
        run_req(1'b0, 16'd0, 16'h0, rd, flt, lat, wes);
        check("ld0_unchanged", 32'(rd), 32'(0));

        for (int n = 0; n < 256; n++) begin
            run_req(1'b0, 16'hFFFF, 16'h0, rd, flt, lat, wes);
            if (n == 0) begin
                check("ldffff_fault", 32'(flt), 32'(1));
                check("ldffff_rdata", 32'(rd), 32'(0));
            end
        end
        @(negedge clk);
        check("sat_count", 32'(fault_count), 32'(255));

        // clear lands in the same cycle as a faulting response
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'hFFFF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (resp_valid) begin seen = 1; break; end
        end
        check("clr_resp_seen", 32'(seen), 32'(1));
        fault_clr = 1'b1;
        @(posedge clk);
        #1 fault_clr = 1'b0;
        check("clr_sticky", 32'(fault_sticky), 32'(0));
        check("clr_count", 32'(fault_count), 32'(0));

        // reset in the WAIT state of a load to 2, with a fault already recorded
        run_req(1'b0, 16'd2000, 16'h0, rd, flt, lat, wes);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'd2;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        Reset = 1'b1;
        #1;
        check("arst_ready", 32'(req_ready), 32'(1));
        check("arst_resp_valid", 32'(resp_valid), 32'(0));
        check("arst_memaddr", 32'(MemAddr), 32'(0));
        check("arst_we", 32'(MemWriteEnable), 32'(0));
        check("arst_sticky", 32'(fault_sticky), 32'(0));
        check("arst_count", 32'(fault_count), 32'(0));
        @(negedge clk);
        Reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) seen = 1;
        end
        check("arst_no_resp", 32'(seen), 32'(0));
        run_req(1'b0, 16'd2, 16'h0, rd, flt, lat, wes);
        check("ld2_after_rst", 32'(rd), 32'(2));

        // READ_LATENCY = 3 with req_valid held high
        @(negedge clk);
        r_valid = 1'b1; r_write = 1'b0; r_addr = 16'd654;
        @(posedge clk);
        lat = -1; seen = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (r_ready) seen = 1;
            if (r_resp_valid) begin lat = k; rd = r_rdata; break; end
        end
        check("rl3_lat", 32'(lat), 32'(5));
        check("rl3_data", 32'(rd), 32'(654));
        check("rl3_ready_low", 32'(seen), 32'(0));
        @(negedge clk);
        check("rl3_ready_after", 32'(r_ready), 32'(1));
        @(posedge clk);
        #1;
        check("rl3_reaccept", 32'(r_ready), 32'(0));
        r_valid = 1'b0;
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer directly upstream of memWrapper. It sits between the datapath's memory stage and the 1024-word, 16-bit synchronous memory.
- Accepts one word request at a time over a valid/ready handshake and drives Addr/DIn/WriteEnable toward memWrapper.
- Waits out the memory's registered read latency, captures DOut and returns a one-cycle response pulse.
- Blocks out-of-range stores before they reach memory and records faults in a sticky flag and a counter.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 16, address width.
- MEM_WORDS, 1024, number of implemented words; valid addresses are 0..MEM_WORDS-1.
- READ_LATENCY, 1, clock edges from memory address capture to valid DOut; range 1..3.

Ports:
- CLK  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  DATA_W  load data; 0 for stores and faults.
- resp_fault  out  1  qualifies resp_valid; access was out of bounds.
- fault_sticky  out  1  set by any fault; cleared by fault_clr.
- fault_clr  in  1  synchronous clear of fault_sticky and fault_count.
- fault_count  out  8  saturating count of faults.
- MemAddr  out  ADDR_W  to memWrapper Addr.
- MemDIn  out  DATA_W  to memWrapper DIn.
- MemWriteEnable  out  1  to memWrapper WriteEnable.
- MemDOut  in  DATA_W  from memWrapper DOut.
- MemOOB  in  1  from memWrapper MemOOB.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous, active-high.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_fault 0, fault_sticky 0, fault_count 0, MemAddr 0, MemDIn 0, MemWriteEnable 0.
  - Reset asserted mid-operation aborts the access.
  - MemWriteEnable drops without waiting for a clock edge.
  - No response is issued for the aborted request.
- Handshake:
  - req_ready is 1 only in IDLE.
  - A request is accepted on a rising edge with req_valid && req_ready.
  - Address, data and write bit are latched into request registers on acceptance.
  - The requester must not change inputs while req_ready is low; they are ignored.
- Bounds check: oob = (latched addr >= MEM_WORDS) || MemOOB, where MemOOB is sampled while MemAddr is driven.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE -> ISSUE on acceptance.
- ISSUE, one cycle:
  - MemAddr and MemDIn are driven from the latched request registers.
  - MemWriteEnable = latched write && !oob.
  - Store goes to RESP. Load goes to WAIT with the wait counter loaded to READ_LATENCY-1.
- WAIT: MemAddr is held.
  - The counter decrements each cycle.
  - When the counter reaches 0, MemDOut is registered into resp_rdata and the FSM goes to RESP.
  - Net timing: load data is valid READ_LATENCY edges after the ISSUE edge.
- RESP, one cycle: resp_valid = 1, resp_fault = latched oob, then IDLE.
  - On a fault, resp_rdata is 0 and the memory contents are unchanged.
- Back-to-back latency:
  - Load: IDLE-accept -> resp_valid at 2+READ_LATENCY cycles. With the default this is 3 cycles, so throughput is one load per 4 cycles.
  - Store: resp_valid at 2 cycles, one store per 3 cycles.
- MemWriteEnable is high in exactly one cycle per in-range store and never outside ISSUE.
- Faults:
  - fault_sticky is set on any faulting response.
  - fault_count increments and saturates at 255.
  - If fault_clr and a fault response occur in the same cycle, clear wins and the new fault is lost. This is documented and intended.
- Address 0xFFFF and address MEM_WORDS exactly are both faults. Address MEM_WORDS-1 is valid.

Decomposition:
- Shared package mem_pkg holds:
  - the FSM state typedef (IDLE/ISSUE/WAIT/RESP);
  - the MEM_WORDS, DATA_W and ADDR_W constants, also used by memWrapper;
  - the FAULT_CNT_W = 8 constant.
- One sub-module, mem_fault_tracker, holds fault_sticky, the saturating counter and the clear priority. The FSM stays in mem_access_unit.

Test Plan:
- Load addr 23 (memory preloaded with word[i] = i) -> resp_valid exactly 3 cycles after acceptance, resp_rdata = 23, resp_fault = 0, MemWriteEnable never high.
- Store 166 -> addr 332, then load 332 -> store resp_valid 2 cycles after acceptance, MemWriteEnable high exactly 1 cycle; the load returns 166.
- Store 0xFFFF -> addr 1023, then load 1023 -> returns 0xFFFF. Store to 1024 -> resp_fault = 1, MemWriteEnable stays 0, fault_sticky = 1, fault_count = 1.
- 256 consecutive faulting loads to 0xFFFF -> fault_count saturates at 255. fault_clr pulsed in the same cycle as a fault response -> both read 0 afterwards.
- Reset asserted in the WAIT of a load to addr 2 -> outputs return to reset values immediately and no resp_valid follows. The next load of addr 2 returns 2.
- READ_LATENCY = 3 build, load addr 654 -> resp_valid 5 cycles after acceptance, resp_rdata = 654. req_valid held high throughout -> the next request is accepted only after RESP.
